// File: rtl/adc_sample_packer_16_if.sv
// Purpose: ADC-side and FIFO-write-side signal bundle for adc_sample_packer_16.
// Latency: none (wires only).
// Backpressure: fifo_full is advisory only; the packer drops rather than stalls.
// Ports (slave = packer view):
//   capture_en, adc_valid, adc_data[15:0], fifo_full      -> into packer
//   fifo_wr_en, fifo_din[31:0], overflow_cnt[CNT_W-1:0], overflow <- from packer
interface adc_sample_packer_16_if #(
    parameter int CNT_W = 16
);
    logic             capture_en;
    logic             adc_valid;
    logic [15:0]      adc_data;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [31:0]      fifo_din;
    logic [CNT_W-1:0] overflow_cnt;
    logic             overflow;

    modport master (
        output capture_en, adc_valid, adc_data, fifo_full,
        input  fifo_wr_en, fifo_din, overflow_cnt, overflow
    );

    modport slave (
        input  capture_en, adc_valid, adc_data, fifo_full,
        output fifo_wr_en, fifo_din, overflow_cnt, overflow
    );
endinterface

// File: rtl/adc_sample_packer_16.sv
// Purpose: packs pairs of 16-bit ADC samples into 32-bit FIFO words, earlier sample in [31:16].
// Latency: word written one cycle after the clock edge that captures its second sample.
// Backpressure: none toward the ADC; a word completing while fifo_full=1 is dropped and counted.
// Ports: clk, rst_n (async active-low); bus (slave modport of adc_sample_packer_16_if):
//   capture_en/adc_valid/adc_data in, fifo_full in, fifo_wr_en/fifo_din out,
//   overflow_cnt (saturating drop count) out, overflow (sticky drop flag) out.
// Optional feature: define PACKER_HDR_EN to insert a {16'hA5A5, frame_cnt} header word
//   after every FRAME_WORDS data words (written or dropped).
module adc_sample_packer_16 #(
    parameter int FRAME_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adc_sample_packer_16_if.slave bus
);

    generate
        if (FRAME_WORDS < 2) begin : g_frame_words_check
            $error("adc_sample_packer_16: FRAME_WORDS must be >= 2");
        end
    endgenerate

    // FIRST: waiting for the upper (earlier) sample; SECOND: upper sample held.
    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } phase_t;

    phase_t           phase;
    phase_t           phase_nxt;
    logic [15:0]      hold;
    logic             take;
    logic             word_done;
    logic             hdr_emit;
    logic             emit;
    logic [31:0]      emit_word;

    logic             wr_en_q;
    logic [31:0]      din_q;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic             ovf_q;

`ifdef PACKER_HDR_EN
    localparam int FW_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [FW_W-1:0] LAST_WORD = FW_W'(FRAME_WORDS - 1);

    logic [FW_W-1:0]  data_cnt;
    logic             hdr_pend;
    logic [15:0]      frame_cnt;
`endif

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= FIRST;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Next phase and word-completion decode
    always_comb begin
        phase_nxt = phase;
        take      = bus.capture_en & bus.adc_valid;
        word_done = 1'b0;
        case (phase)
            FIRST: begin
                if (take) begin
                    phase_nxt = SECOND;
                end
            end
            SECOND: begin
                // Dropping capture_en abandons a half-built pair.
                if (!bus.capture_en) begin
                    phase_nxt = FIRST;
                end else if (bus.adc_valid) begin
                    word_done = 1'b1;
                    phase_nxt = FIRST;
                end
            end
            default: phase_nxt = FIRST;
        endcase
    end

    // Header slots in only where no data word completes; data and header never
    // compete for the same cycle, so a single drop source exists per cycle.
    always_comb begin
`ifdef PACKER_HDR_EN
        hdr_emit  = hdr_pend & bus.capture_en & ~word_done;
        emit_word = word_done ? {hold, bus.adc_data} : {16'hA5A5, frame_cnt};
`else
        hdr_emit  = 1'b0;
        emit_word = {hold, bus.adc_data};
`endif
        emit = word_done | hdr_emit;
    end

    // Upper-sample hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= 16'h0000;
        end else if ((phase == FIRST) && take) begin
            hold <= bus.adc_data;
        end
    end

    // Registered FIFO write port and overflow accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            din_q     <= 32'h0000_0000;
            ovf_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_en_q <= emit & ~bus.fifo_full;
            if (emit && !bus.fifo_full) begin
                din_q <= emit_word;
            end
            if (emit && bus.fifo_full) begin
                ovf_q <= 1'b1;
                if (ovf_cnt_q != {CNT_W{1'b1}}) begin
                    ovf_cnt_q <= ovf_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef PACKER_HDR_EN
    // Frame bookkeeping: data_cnt counts completed words in the current frame,
    // hdr_pend marks a header owed, frame_cnt numbers headers (emitted or dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cnt  <= '0;
            hdr_pend  <= 1'b0;
            frame_cnt <= 16'h0000;
        end else if (!bus.capture_en) begin
            hdr_pend <= 1'b0;
        end else begin
            if (hdr_emit) begin
                hdr_pend  <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (word_done) begin
                if (data_cnt == LAST_WORD) begin
                    data_cnt <= '0;
                    hdr_pend <= 1'b1;
                end else begin
                    data_cnt <= data_cnt + 1'b1;
                end
            end
        end
    end
`endif

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_din     = din_q;
    assign bus.overflow_cnt = ovf_cnt_q;
    assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_adc_sample_packer_16.sv
// Bench for adc_sample_packer_16: vector table, reset/saturation/header sequences,
// and randomized traffic against a queue-based reference model.
module tb_adc_sample_packer_16;

    localparam int CNT_W = 4;
    localparam int FW    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_sample_packer_16_if #(.CNT_W(CNT_W)) bus ();

    adc_sample_packer_16 #(
        .FRAME_WORDS(FW),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0]      m_q[$];
    int               m_words;
    int               m_hdr_owed;
    logic [15:0]      m_frames;
    logic             exp_wr;
    logic [31:0]      exp_din;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ovf;

    typedef struct {
        logic             cap;
        logic             vld;
        logic [15:0]      dat;
        logic             full;
        logic             wr;
        logic [31:0]      din;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_words    = 0;
        m_hdr_owed = 0;
        m_frames   = 16'h0000;
        exp_wr     = 1'b0;
        exp_din    = 32'h0;
        exp_cnt    = '0;
        exp_ovf    = 1'b0;
    endtask

    task automatic model_emit(input logic [31:0] w, input logic full);
        if (full) begin
            exp_ovf = 1'b1;
            if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end else begin
            exp_wr  = 1'b1;
            exp_din = w;
        end
    endtask

    // One cycle of behaviour: samples queue up, every second one forms a word.
    task automatic model_step(input logic cap, input logic vld,
                              input logic [15:0] dat, input logic full);
        logic made;
        made   = 1'b0;
        exp_wr = 1'b0;
        if (!cap) begin
            m_q.delete();
            m_hdr_owed = 0;
        end else begin
            if (vld) begin
                m_q.push_back(dat);
                if (m_q.size() == 2) begin
                    model_emit({m_q[0], m_q[1]}, full);
                    m_q.delete();
                    made = 1'b1;
                    m_words++;
                    if (m_words == FW) begin
                        m_words = 0;
`ifdef PACKER_HDR_EN
                        m_hdr_owed++;
`endif
                    end
                end
            end
            if (!made && m_hdr_owed > 0) begin
                model_emit({16'hA5A5, m_frames}, full);
                m_frames   = m_frames + 16'd1;
                m_hdr_owed = m_hdr_owed - 1;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " wr_en"},    {31'd0, bus.fifo_wr_en}, {31'd0, exp_wr});
        chk({tag, " din"},      bus.fifo_din, exp_din);
        chk({tag, " ovf_cnt"},  32'(bus.overflow_cnt), 32'(exp_cnt));
        chk({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic drive(input logic cap, input logic vld,
                         input logic [15:0] dat, input logic full, input string tag);
        bus.capture_en = cap;
        bus.adc_valid  = vld;
        bus.adc_data   = dat;
        bus.fifo_full  = full;
        @(posedge clk);
        #1;
        model_step(cap, vld, dat, full);
        chk_model(tag);
    endtask

    task automatic do_reset();
        bus.capture_en = 1'b0;
        bus.adc_valid  = 1'b0;
        bus.adc_data   = 16'h0;
        bus.fifo_full  = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic cap, input logic vld, input logic [15:0] dat,
                       input logic full, input logic wr, input logic [31:0] din,
                       input logic [CNT_W-1:0] cnt, input logic ovf);
        vec_t v;
        v.cap = cap; v.vld = vld; v.dat = dat; v.full = full;
        v.wr = wr; v.din = din; v.cnt = cnt; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    logic [31:0] got_w[$];
    logic [31:0] want_w[$];

    initial begin
        do_reset();

`ifndef PACKER_HDR_EN
        // Pair of samples
        add(1, 1, 16'h1111, 0, 0, 32'h0000_0000, 0, 0);
        add(1, 1, 16'h2222, 0, 1, 32'h1111_2222, 0, 0);
        add(1, 0, 16'h0000, 0, 0, 32'h1111_2222, 0, 0);
        // Continuous 0..7
        for (int i = 0; i < 8; i++)
            add(1, 1, 16'(i), 0, (i % 2) == 1,
                (i % 2) == 1 ? {16'(i - 1), 16'(i)} :
                (i == 0 ? 32'h1111_2222 : {16'(i - 2), 16'(i - 1)}), 0, 0);
        add(1, 0, 16'h0000, 0, 0, 32'h0006_0007, 0, 0);
        // Three dropped words, then one written
        add(1, 1, 16'hA0A0, 1, 0, 32'h0006_0007, 0, 0);
        add(1, 1, 16'hA1A1, 1, 0, 32'h0006_0007, 1, 1);
        add(1, 1, 16'hA2A2, 1, 0, 32'h0006_0007, 1, 1);
        add(1, 1, 16'hA3A3, 1, 0, 32'h0006_0007, 2, 1);
        add(1, 1, 16'hA4A4, 1, 0, 32'h0006_0007, 2, 1);
        add(1, 1, 16'hA5A5, 1, 0, 32'h0006_0007, 3, 1);
        add(1, 1, 16'hB0B0, 0, 0, 32'h0006_0007, 3, 1);
        add(1, 1, 16'hB1B1, 0, 1, 32'hB0B0_B1B1, 3, 1);
        add(1, 0, 16'h0000, 0, 0, 32'hB0B0_B1B1, 3, 1);
        // Half pair abandoned by capture_en
        add(1, 1, 16'hAAAA, 0, 0, 32'hB0B0_B1B1, 3, 1);
        add(0, 1, 16'h1234, 0, 0, 32'hB0B0_B1B1, 3, 1);
        add(1, 1, 16'hBBBB, 0, 0, 32'hB0B0_B1B1, 3, 1);
        add(1, 1, 16'hCCCC, 0, 1, 32'hBBBB_CCCC, 3, 1);
        add(1, 0, 16'h0000, 0, 0, 32'hBBBB_CCCC, 3, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.capture_en = tbl[i].cap;
            bus.adc_valid  = tbl[i].vld;
            bus.adc_data   = tbl[i].dat;
            bus.fifo_full  = tbl[i].full;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d wr_en", i), {31'd0, bus.fifo_wr_en}, {31'd0, tbl[i].wr});
            chk($sformatf("vec%0d din", i), bus.fifo_din, tbl[i].din);
            chk($sformatf("vec%0d ovf_cnt", i), 32'(bus.overflow_cnt), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d overflow", i), {31'd0, bus.overflow}, {31'd0, tbl[i].ovf});
        end
`else
        // Headers every two data words
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, i < 8, 16'(i), 1'b0, $sformatf("hdr%0d", i));
            if (bus.fifo_wr_en) got_w.push_back(bus.fifo_din);
        end
        want_w = '{32'h0000_0001, 32'h0002_0003, 32'hA5A5_0000,
                   32'h0004_0005, 32'h0006_0007, 32'hA5A5_0001};
        chk("hdr word count", 32'(got_w.size()), 32'(want_w.size()));
        for (int i = 0; i < want_w.size() && i < got_w.size(); i++)
            chk($sformatf("hdr word%0d", i), got_w[i], want_w[i]);
`endif

        // Async reset mid-pair with overflow_cnt = 5
        do_reset();
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, 16'(16'h5000 + i), 1'b1, "pre_rst");
        chk("pre_rst count", 32'(bus.overflow_cnt), 32'd5);
        drive(1'b1, 1'b1, 16'h7777, 1'b0, "half_pair");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
        chk("async rst din", bus.fifo_din, 32'd0);
        chk("async rst ovf_cnt", 32'(bus.overflow_cnt), 32'd0);
        chk("async rst overflow", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 1'b1, 16'hDDDD, 1'b0, "post_rst0");
        drive(1'b1, 1'b1, 16'hEEEE, 1'b0, "post_rst1");
        chk("post_rst word", bus.fifo_din, 32'hDDDD_EEEE);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, "post_rst2");

        // Saturation of the drop counter
        do_reset();
        for (int i = 0; i < 40; i++)
            drive(1'b1, 1'b1, 16'(i), 1'b1, "sat");
        chk("saturated count", 32'(bus.overflow_cnt), 32'((1 << CNT_W) - 1));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                  16'($urandom), $urandom_range(0, 9) < 3, "rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
